i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits (2 bytes) and address width at 7 bits.
REQ-002 CLK  input  1  system clock; all state is updated on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 SCL  input  1  bus clock from the controller, sampled on CLK.
REQ-005 SDA_OUT  input  1  controller's SDA drive value.
REQ-006 SDA_OE  input  1  controller drive enable; the line value is SDA_OUT when SDA_OE=1 and 1 (pull-up) otherwise.
REQ-007 I2C_ADDR  input  7  this target's own address.
REQ-008 RD_DATA  input  16  word returned on reads; captured at address ACK.
REQ-009 SDA_IN  output  1  target drive toward the controller; 1 = released, 0 = pull low.
REQ-010 WR_DATA  output  16  last complete word received.
REQ-011 WR_VALID  output  1  one-CLK pulse when WR_DATA updates.
REQ-012 BUSY  output  1  high from a START until the next STOP.

Function
REQ-013 The line value SHALL be SDA_OUT when SDA_OE=1 and 1 otherwise; SCL and SDA SHALL be registered, and edges SHALL be detected against the previous sample.
REQ-014 START SHALL be detected when the SDA line falls while SCL=1; STOP SHALL be detected when the SDA line rises while SCL=1.
REQ-015 A START SHALL enter ADDR from any state (this covers repeated START); a STOP SHALL enter IDLE from any state, set SDA_IN=1 and clear BUSY.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-017 Bits SHALL be sampled on the detected SCL rising edge, MSB first, with a 3-bit bit counter per byte.
REQ-018 ADDR: 8 bits are received (7 address bits + RNW). On a match with I2C_ADDR, go to ADDR_ACK; on a mismatch, go to IGNORE with SDA_IN=1 until STOP or START.
REQ-019 ACK drive: SDA_IN SHALL go to 0 on the SCL falling edge that follows the 8th bit, and SHALL be released on the following SCL falling edge.
REQ-020 Write (RNW=0): byte 0 goes to the upper 8 bits and byte 1 to the lower 8 bits, each ACKed. After byte 1's ACK, WR_DATA SHALL update and WR_VALID SHALL pulse for one CLK.
REQ-021 A third or later write byte SHALL be NACKed (SDA_IN=1) and discarded; WR_DATA SHALL remain unchanged.
REQ-022 A STOP or START before byte 1 completes SHALL discard the partial word and SHALL NOT pulse WR_VALID.
REQ-023 Read (RNW=1): RD_DATA is latched at ADDR_ACK. SDA_IN SHALL present bits MSB first, changing only on SCL falling edges; the first bit is driven on the falling edge that ends ADDR_ACK.
REQ-024 RD_ACK: SDA_IN is released and the controller's bit is sampled on the SCL rising edge.
 - ACK (0) after byte 0: send byte 1.
 - ACK after byte 1: wrap and resend the upper byte.
 - NACK: go to IGNORE.
REQ-025 SDA_IN SHALL NOT change while SCL=1 except on a STOP, START or reset.
REQ-026 If START and an SCL edge are seen in the same CLK, START SHALL take priority.

Reset
REQ-027 While RESET=0, the outputs SHALL be: state IDLE, SDA_IN=1, WR_DATA=16'h0000, WR_VALID=0, BUSY=0, all counters and shift registers 0.
REQ-028 Assertion of RESET mid-transfer SHALL abort the transfer immediately; after release, the block SHALL ignore the bus until the next START.

Configuration
REQ-029 Macro I2C_TARGET_GLITCH_FILTER_EN.
 - When defined: SCL and SDA each pass through a 2-flop synchronizer and then a 3-sample majority filter before edge detection, giving a detection latency of 4 CLK.
 - When undefined: a single register stage is used, giving a detection latency of 1 CLK; the protocol behaviour is otherwise identical.

Verification
REQ-030 Write: I2C_ADDR=7'b0011010, address byte 0x34, data 0xAA then 0xAD -> three ACKs (SDA_IN=0), WR_DATA=16'hAAAD, exactly one WR_VALID pulse.
REQ-031 Read: address byte 0x35, RD_DATA=16'hEEED, controller ACKs byte 0 and NACKs byte 1 -> SDA_IN carries 0xEE then 0xED; state IGNORE; after STOP, BUSY=0.
REQ-032 Address mismatch: address byte 0x36 -> SDA_IN stays 1 for the entire transfer, WR_VALID=0, WR_DATA unchanged.
REQ-033 Abort: STOP after 0x34 and 0xEA -> no WR_VALID, WR_DATA keeps its previous value; a following full write of 0xEA, 0xBD -> WR_DATA=16'hEABD.
REQ-034 Reset: RESET=0 during the 5th bit of a write byte -> SDA_IN=1, WR_DATA=0 and BUSY=0 immediately; after release, a new transfer succeeds.
REQ-035 Run REQ-030 and REQ-031 both with and without I2C_TARGET_GLITCH_FILTER_EN; additionally, with the macro defined, a 1-CLK SCL glitch SHALL NOT advance the bit counter.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: 7-bit-address I2C target moving one 16-bit word per transfer.
// Optional SCL/SDA glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SCL,
   input  logic        SDA_OUT,
   input  logic        SDA_OE,
   input  logic [6:0]  I2C_ADDR,
   input  logic [15:0] RD_DATA,
   output logic        SDA_IN,
   output logic [15:0] WR_DATA,
   output logic        WR_VALID,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE,
      WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   state_t      r_state;
   logic        r_scl, r_sda;
   logic        r_scl_d, r_sda_d;
   logic [2:0]  r_bitcnt;
   logic [6:0]  r_shift;
   logic        r_rnw;
   logic        r_phase;
   logic [1:0]  r_wr_cnt;
   logic [7:0]  r_wr_hi, r_wr_lo;
   logic [15:0] r_rd_word;
   logic        r_rd_sel;
   logic        r_sda_in;
   logic [15:0] r_wr_data;
   logic        r_wr_valid;
   logic        r_busy;

   logic        w_sda_line;
   logic        w_scl_rise, w_scl_fall;
   logic        w_start, w_stop;
   logic        w_bit_last;
   logic [7:0]  w_byte;
   logic [7:0]  w_rd_byte;

   assign w_sda_line = SDA_OE ? SDA_OUT : 1'b1;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] r_scl_sync, r_sda_sync;
   logic [1:0] r_scl_hist, r_sda_hist;
   logic       w_scl_maj, w_sda_maj;

   assign w_scl_maj = (r_scl_sync[1] & r_scl_hist[0]) |
                      (r_scl_sync[1] & r_scl_hist[1]) |
                      (r_scl_hist[0] & r_scl_hist[1]);
   assign w_sda_maj = (r_sda_sync[1] & r_sda_hist[0]) |
                      (r_sda_sync[1] & r_sda_hist[1]) |
                      (r_sda_hist[0] & r_sda_hist[1]);

   // Synchronize both bus lines, then take a 3-sample majority vote.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_hist <= 2'b11;
         r_sda_hist <= 2'b11;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], SCL};
         r_sda_sync <= {r_sda_sync[0], w_sda_line};
         r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
         r_scl      <= w_scl_maj;
         r_sda      <= w_sda_maj;
      end
   end
`else
   // Single register stage on both bus lines.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_scl <= 1'b1;
         r_sda <= 1'b1;
      end else begin
         r_scl <= SCL;
         r_sda <= w_sda_line;
      end
   end
`endif

   // Previous sample of each line for edge detection.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_scl_d <= 1'b1;
         r_sda_d <= 1'b1;
      end else begin
         r_scl_d <= r_scl;
         r_sda_d <= r_sda;
      end
   end

   assign w_scl_rise = r_scl & ~r_scl_d;
   assign w_scl_fall = ~r_scl & r_scl_d;
   assign w_start    = r_scl & r_sda_d & ~r_sda;
   assign w_stop     = r_scl & ~r_sda_d & r_sda;
   assign w_bit_last = (r_bitcnt == 3'd7);
   assign w_byte     = {r_shift, r_sda};
   assign w_rd_byte  = r_rd_sel ? r_rd_word[7:0] : r_rd_word[15:8];

   // Protocol FSM; START outranks everything, STOP outranks bit edges.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= IDLE;
         r_bitcnt   <= 3'd0;
         r_shift    <= 7'd0;
         r_rnw      <= 1'b0;
         r_phase    <= 1'b0;
         r_wr_cnt   <= 2'd0;
         r_wr_hi    <= 8'd0;
         r_wr_lo    <= 8'd0;
         r_rd_word  <= 16'd0;
         r_rd_sel   <= 1'b0;
         r_sda_in   <= 1'b1;
         r_wr_data  <= 16'd0;
         r_wr_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_wr_valid <= 1'b0;
         if (w_start) begin
            r_state  <= ADDR;
            r_busy   <= 1'b1;
            r_sda_in <= 1'b1;
            r_bitcnt <= 3'd0;
            r_shift  <= 7'd0;
            r_phase  <= 1'b0;
            r_wr_cnt <= 2'd0;
         end else if (w_stop) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_sda_in <= 1'b1;
            r_bitcnt <= 3'd0;
            r_phase  <= 1'b0;
         end else begin
            case (r_state)
               ADDR: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte[6:0];
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (w_bit_last) begin
                        if (w_byte[7:1] == I2C_ADDR) begin
                           r_state   <= ADDR_ACK;
                           r_rnw     <= w_byte[0];
                           r_rd_word <= RD_DATA;
                           r_rd_sel  <= 1'b0;
                        end else begin
                           r_state <= IGNORE;
                        end
                     end
                  end
               end
               ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_phase) begin
                        r_sda_in <= 1'b0;
                        r_phase  <= 1'b1;
                     end else begin
                        r_phase  <= 1'b0;
                        r_bitcnt <= 3'd0;
                        if (r_rnw) begin
                           r_state  <= RD_BYTE;
                           r_sda_in <= r_rd_word[15];
                        end else begin
                           r_state  <= WR_BYTE;
                           r_sda_in <= 1'b1;
                        end
                     end
                  end
               end
               WR_BYTE: begin
                  if (w_scl_rise) begin
                     r_shift  <= w_byte[6:0];
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (w_bit_last) begin
                        r_state <= WR_ACK;
                        if (r_wr_cnt == 2'd0)
                           r_wr_hi <= w_byte;
                        else if (r_wr_cnt == 2'd1)
                           r_wr_lo <= w_byte;
                     end
                  end
               end
               WR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_phase) begin
                        r_sda_in <= (r_wr_cnt == 2'd2);
                        r_phase  <= 1'b1;
                     end else begin
                        r_phase  <= 1'b0;
                        r_sda_in <= 1'b1;
                        r_bitcnt <= 3'd0;
                        r_state  <= WR_BYTE;
                        if (r_wr_cnt == 2'd1) begin
                           r_wr_data  <= {r_wr_hi, r_wr_lo};
                           r_wr_valid <= 1'b1;
                        end
                        if (r_wr_cnt != 2'd2)
                           r_wr_cnt <= r_wr_cnt + 2'd1;
                     end
                  end
               end
               RD_BYTE: begin
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (w_bit_last)
                        r_state <= RD_ACK;
                  end else if (w_scl_fall) begin
                     r_sda_in <= w_rd_byte[3'd7 - r_bitcnt];
                  end
               end
               RD_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_phase) begin
                        r_sda_in <= 1'b1;
                     end else begin
                        r_phase  <= 1'b0;
                        r_bitcnt <= 3'd0;
                        r_state  <= RD_BYTE;
                        r_sda_in <= w_rd_byte[7];
                     end
                  end else if (w_scl_rise && !r_phase) begin
                     if (r_sda) begin
                        r_state  <= IGNORE;
                        r_sda_in <= 1'b1;
                     end else begin
                        r_phase  <= 1'b1;
                        r_rd_sel <= ~r_rd_sel;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign SDA_IN   = r_sda_in;
   assign WR_DATA  = r_wr_data;
   assign WR_VALID = r_wr_valid;
   assign BUSY     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller with an SDA_IN scoreboard.
// Vector table for whole transfers plus reset, repeated-START and glitch sequences.
module tb_i2c_target;

   localparam int T = 8;
   localparam logic [6:0] MY_ADDR = 7'b0011010;

   logic        CLK;
   logic        RESET;
   logic        SCL;
   logic        SDA_OUT;
   logic        SDA_OE;
   logic [6:0]  I2C_ADDR;
   logic [15:0] RD_DATA;
   logic        SDA_IN;
   logic [15:0] WR_DATA;
   logic        WR_VALID;
   logic        BUSY;

   int checks;
   int failures;
   int vcount;
   logic exp_q[$];

   typedef struct {
      logic [7:0]  addr;
      int          n;
      logic [7:0]  d0, d1, d2;
      logic [15:0] rd;
      logic [15:0] exp_wr;
      int          exp_p;
   } vec_t;

   vec_t vecs[8];

   i2c_target u_dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .SCL      (SCL),
      .SDA_OUT  (SDA_OUT),
      .SDA_OE   (SDA_OE),
      .I2C_ADDR (I2C_ADDR),
      .RD_DATA  (RD_DATA),
      .SDA_IN   (SDA_IN),
      .WR_DATA  (WR_DATA),
      .WR_VALID (WR_VALID),
      .BUSY     (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count WR_VALID pulses.
   always @(negedge CLK) begin
      if (WR_VALID === 1'b1) vcount++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [7:0] a, input int n,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [15:0] rd,
                               input logic [15:0] ew, input int ep);
      vec_t v;
      v.addr = a; v.n = n; v.d0 = d0; v.d1 = d1; v.d2 = d2;
      v.rd = rd; v.exp_wr = ew; v.exp_p = ep;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pop_chk(input string nm);
      logic e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got %b", nm, SDA_IN);
      end else begin
         e = exp_q.pop_front();
         chk(nm, {15'd0, SDA_IN}, {15'd0, e});
      end
   endtask

   task automatic i2c_start();
      SDA_OE = 1'b0; tick(T);
      SCL = 1'b1; tick(T);
      SDA_OE = 1'b1; SDA_OUT = 1'b0; tick(T);
      SCL = 1'b0; tick(T);
   endtask

   task automatic i2c_stop();
      SDA_OE = 1'b1; SDA_OUT = 1'b0; tick(T);
      SCL = 1'b1; tick(T);
      SDA_OE = 1'b0; tick(T);
   endtask

   // Controller drives a bit; target must keep SDA_IN released.
   task automatic write_bit(input logic b, input bit glitch);
      SDA_OE = 1'b1; SDA_OUT = b;
      if (glitch) begin
         tick(3); SCL = 1'b1; tick(1); SCL = 1'b0; tick(T - 4);
      end else begin
         tick(T);
      end
      SCL = 1'b1;
      exp_q.push_back(1'b1);
      tick(T / 2);
      pop_chk("ctl_bit_released");
      tick(T / 2);
      SCL = 1'b0; tick(T);
   endtask

   // Slot driven by the target; expected value already queued.
   task automatic tgt_bit(input string nm);
      SDA_OE = 1'b0; tick(T);
      SCL = 1'b1; tick(T / 2);
      pop_chk(nm);
      tick(T / 2);
      SCL = 1'b0; tick(T);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask);
      for (int i = 7; i >= 0; i--) write_bit(b[i], gmask[i]);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      logic       match;
      logic [7:0] b;
      int         v0;
      match = (v.addr[7:1] == MY_ADDR);
      v0 = vcount;
      RD_DATA = v.rd;
      i2c_start();
      chk({nm, "_busy_start"}, {15'd0, BUSY}, 16'd1);
      send_byte(v.addr, 8'h00);
      exp_q.push_back(!match);
      tgt_bit({nm, "_addr_ack"});
      if (!v.addr[0]) begin
         for (int i = 0; i < v.n; i++) begin
            b = (i == 0) ? v.d0 : (i == 1) ? v.d1 : v.d2;
            send_byte(b, 8'h00);
            exp_q.push_back(!(match && i < 2));
            tgt_bit({nm, "_wr_ack"});
         end
      end else if (match) begin
         for (int i = 0; i < v.n; i++) begin
            b = (i % 2 == 0) ? v.rd[15:8] : v.rd[7:0];
            for (int k = 7; k >= 0; k--) begin
               exp_q.push_back(b[k]);
               tgt_bit({nm, "_rd_bit"});
            end
            write_bit(i == v.n - 1, 1'b0);
         end
      end
      chk({nm, "_busy_pre_stop"}, {15'd0, BUSY}, 16'd1);
      i2c_stop();
      chk({nm, "_busy_stop"}, {15'd0, BUSY}, 16'd0);
      chk({nm, "_wr_data"}, WR_DATA, v.exp_wr);
      chk({nm, "_valid_cnt"}, 16'(vcount - v0), 16'(v.exp_p));
   endtask

   initial begin
      int v0;
      checks = 0; failures = 0; vcount = 0;
      RESET = 1'b0; SCL = 1'b1; SDA_OUT = 1'b1; SDA_OE = 1'b0;
      I2C_ADDR = MY_ADDR; RD_DATA = 16'h0000;

      vecs[0] = mk(8'h34, 2, 8'hAA, 8'hAD, 8'h00, 16'h0000, 16'hAAAD, 1);
      vecs[1] = mk(8'h35, 2, 8'h00, 8'h00, 8'h00, 16'hEEED, 16'hAAAD, 0);
      vecs[2] = mk(8'h36, 2, 8'h12, 8'h34, 8'h00, 16'h0000, 16'hAAAD, 0);
      vecs[3] = mk(8'h34, 1, 8'hEA, 8'h00, 8'h00, 16'h0000, 16'hAAAD, 0);
      vecs[4] = mk(8'h34, 2, 8'hEA, 8'hBD, 8'h00, 16'h0000, 16'hEABD, 1);
      vecs[5] = mk(8'h34, 3, 8'h11, 8'h22, 8'h33, 16'h0000, 16'h1122, 1);
      vecs[6] = mk(8'h35, 3, 8'h00, 8'h00, 8'h00, 16'h1234, 16'h1122, 0);
      vecs[7] = mk(8'h37, 0, 8'h00, 8'h00, 8'h00, 16'hFFFF, 16'h1122, 0);

      tick(3);
      chk("rst_sda_in", {15'd0, SDA_IN}, 16'd1);
      chk("rst_wr_data", WR_DATA, 16'h0000);
      chk("rst_wr_valid", {15'd0, WR_VALID}, 16'd0);
      chk("rst_busy", {15'd0, BUSY}, 16'd0);
      RESET = 1'b1;
      tick(T);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Repeated START mid-word discards the partial word.
      v0 = vcount;
      i2c_start();
      send_byte(8'h34, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("rs_addr_ack");
      send_byte(8'h55, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("rs_b0_ack");
      i2c_start();
      chk("rs_busy", {15'd0, BUSY}, 16'd1);
      send_byte(8'h34, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("rs_addr2_ack");
      send_byte(8'h66, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("rs_d0_ack");
      send_byte(8'h77, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("rs_d1_ack");
      i2c_stop();
      chk("rs_wr_data", WR_DATA, 16'h6677);
      chk("rs_valid_cnt", 16'(vcount - v0), 16'd1);

      // Reset asserted during the 5th bit of a write byte.
      v0 = vcount;
      i2c_start();
      send_byte(8'h34, 8'h00);
      exp_q.push_back(1'b0); tgt_bit("mr_addr_ack");
      for (int k = 7; k >= 4; k--) write_bit(k[0] ^ k[1], 1'b0);
      SDA_OE = 1'b1; SDA_OUT = 1'b1; tick(T);
      SCL = 1'b1; tick(2);
      RESET = 1'b0;
      #1;
      chk("mr_sda_in", {15'd0, SDA_IN}, 16'd1);
      chk("mr_wr_data", WR_DATA, 16'h0000);
      chk("mr_busy", {15'd0, BUSY}, 16'd0);
      tick(2);
      SDA_OE = 1'b0; tick(4);
      RESET = 1'b1; tick(T);
      SCL = 1'b0; tick(T);
      for (int k = 2; k >= 0; k--) write_bit(1'b0, 1'b0);
      exp_q.push_back(1'b1); tgt_bit("mr_ignore_ack");
      chk("mr_busy_ignored", {15'd0, BUSY}, 16'd0);
      i2c_stop();
      chk("mr_valid_cnt", 16'(vcount - v0), 16'd0);
      run_vec(mk(8'h34, 2, 8'h0F, 8'hF0, 8'h00, 16'h0000, 16'h0FF0, 1),
              "post_rst");

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // One-CLK SCL glitches in the low phase must not count as bits.
      v0 = vcount;
      i2c_start();
      send_byte(8'h34, 8'h21);
      exp_q.push_back(1'b0); tgt_bit("gl_addr_ack");
      send_byte(8'h5A, 8'h84);
      exp_q.push_back(1'b0); tgt_bit("gl_d0_ack");
      send_byte(8'hC3, 8'h10);
      exp_q.push_back(1'b0); tgt_bit("gl_d1_ack");
      i2c_stop();
      chk("gl_wr_data", WR_DATA, 16'h5AC3);
      chk("gl_valid_cnt", 16'(vcount - v0), 16'd1);
`endif

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_drain: %0d left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
